// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with maskable interrupt.
// Registers: 0x0 CTRL {IM, Mode[1:0], Enable}, 0x4 PRESET, 0x8 COUNT (RO), 0xC reads 0.
// Build option: define TIMER_AUTORELOAD_EN to enable mode 1 (periodic auto-reload);
// without it the Mode field is hardwired to 0 and every expiry is one-shot.
module timer_device #(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    logic        en;
    logic        im;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        reload;
    logic        ctrl_wr;
    logic        preset_wr;

    // Only Addr[3:2] is decoded; the bridge has already qualified the upper bits.
    logic        unused_addr;
    assign unused_addr = ^Addr[31:4];

`ifndef TIMER_AUTORELOAD_EN
    // Mode field does not exist in this build: always one-shot.
    assign mode = '0;
`endif

    assign ctrl_wr   = WE && (Addr[3:2] == 2'd0);
    assign preset_wr = WE && (Addr[3:2] == 2'd1);

    // Mode 1 is the only periodic mode; 2 and 3 fall back to one-shot.
    assign reload = (mode == 2'd1);

    assign IRQ = im & irq_flag;

    // Register file and countdown FSM; a CTRL write overrides the FSM on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            en       <= 1'b0;
            im       <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            mode     <= '0;
`endif
            preset   <= RESET_PRESET;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset <= Din;
            end
            if (ctrl_wr) begin
                en       <= Din[0];
                im       <= Din[3];
`ifdef TIMER_AUTORELOAD_EN
                mode     <= Din[2:1];
`endif
                state    <= IDLE;
                irq_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        count <= preset;
                        state <= CNT;
                    end
                    CNT: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (count == '0) begin
                            state    <= INT;
                            irq_flag <= 1'b1;
                        end else begin
                            count <= count - 32'd1;
                        end
                    end
                    INT: begin
                        if (reload) begin
                            irq_flag <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            en    <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Combinational read mux.
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, im, mode, en};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device.
module tb_timer_device;

    localparam logic [31:0] RP = 32'hA5A5_0001;

    logic        clk;
    logic        reset;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks;
    int failures;

    timer_device #(.RESET_PRESET(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (addr),
        .WE    (we),
        .Din   (din),
        .Dout  (dout),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int off, input logic [31:0] d);
        addr = 30'(off);
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic rd(input int off);
        addr = 30'(off);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        we    = 1'b1;
        addr  = '0;
        din   = 32'hF;
        tick();
        tick();
        reset = 1'b0;
        we    = 1'b0;
        din   = '0;
        rd(0);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", dout, 32'h0); end
        rd(1);
        checks++; if (dout !== RP) begin failures++; $display("FAIL reset_preset got=%h exp=%h", dout, RP); end
        rd(2);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", dout, 32'h0); end
        rd(3);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_reg3 got=%h exp=%h", dout, 32'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_oneshot();
        bus_write(1, 32'd5);
        rd(1);
        checks++; if (dout !== 32'd5) begin failures++; $display("FAIL oneshot_preset got=%h exp=%h", dout, 32'd5); end
        bus_write(0, 32'h9);
        rd(0);
        checks++; if (dout !== 32'h9) begin failures++; $display("FAIL oneshot_ctrl_T got=%h exp=%h", dout, 32'h9); end
        tick();
        for (int k = 2; k <= 7; k++) begin
            tick();
            rd(2);
            checks++; if (dout !== 32'(7 - k)) begin failures++; $display("FAIL oneshot_count T+%0d got=%h exp=%h", k, dout, 32'(7 - k)); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_early T+%0d got=%b exp=0", k, irq); end
        end
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_T8 got=%b exp=1", irq); end
        rd(0);
        checks++; if (dout !== 32'h9) begin failures++; $display("FAIL oneshot_ctrl_T8 got=%h exp=%h", dout, 32'h9); end
        tick();
        rd(0);
        checks++; if (dout !== 32'h8) begin failures++; $display("FAIL oneshot_ctrl_T9 got=%h exp=%h", dout, 32'h8); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_T9 got=%b exp=1", irq); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_held %0d got=%b exp=1", k, irq); end
        end
        bus_write(0, 32'h0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
    endtask

`ifdef TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        logic exp_irq;
        bus_write(1, 32'd3);
        bus_write(0, 32'hB);
        rd(0);
        checks++; if (dout !== 32'hB) begin failures++; $display("FAIL reload_ctrl got=%h exp=%h", dout, 32'hB); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_irq = (k >= 6) && (((k - 6) % 6) == 0);
            checks++; if (irq !== exp_irq) begin failures++; $display("FAIL reload_irq T+%0d got=%b exp=%b", k, irq, exp_irq); end
            if (k >= 2 && ((k - 2) % 6) == 0) begin
                rd(2);
                checks++; if (dout !== 32'd3) begin failures++; $display("FAIL reload_count T+%0d got=%h exp=%h", k, dout, 32'd3); end
            end
        end
        bus_write(0, 32'h0);
        // Mode 2 must behave as one-shot.
        bus_write(1, 32'd1);
        bus_write(0, 32'hD);
        rd(0);
        checks++; if (dout !== 32'hD) begin failures++; $display("FAIL mode2_ctrl got=%h exp=%h", dout, 32'hD); end
        repeat (4) tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mode2_irq got=%b exp=1", irq); end
        tick();
        rd(0);
        checks++; if (dout !== 32'hC) begin failures++; $display("FAIL mode2_ctrl_after got=%h exp=%h", dout, 32'hC); end
        repeat (5) tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mode2_irq_held got=%b exp=1", irq); end
        bus_write(0, 32'h0);
    endtask
`else
    task automatic test_mode_hardwired();
        bus_write(1, 32'd1);
        bus_write(0, 32'hB);
        rd(0);
        checks++; if (dout !== 32'h9) begin failures++; $display("FAIL hw_mode_ctrl got=%h exp=%h", dout, 32'h9); end
        repeat (4) tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL hw_mode_irq got=%b exp=1", irq); end
        tick();
        rd(0);
        checks++; if (dout !== 32'h8) begin failures++; $display("FAIL hw_mode_ctrl_after got=%h exp=%h", dout, 32'h8); end
        repeat (5) tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL hw_mode_irq_held got=%b exp=1", irq); end
        bus_write(0, 32'h0);
    endtask
`endif

    task automatic test_midcount_stop();
        bus_write(1, 32'd5);
        bus_write(0, 32'h9);
        repeat (5) tick();
        rd(2);
        checks++; if (dout !== 32'd2) begin failures++; $display("FAIL mid_count_pre got=%h exp=%h", dout, 32'd2); end
        bus_write(0, 32'h8);
        rd(2);
        checks++; if (dout !== 32'd2) begin failures++; $display("FAIL mid_count_stop got=%h exp=%h", dout, 32'd2); end
        rd(0);
        checks++; if (dout !== 32'h8) begin failures++; $display("FAIL mid_ctrl got=%h exp=%h", dout, 32'h8); end
        for (int k = 0; k < 4; k++) begin
            tick();
            rd(2);
            checks++; if (dout !== 32'd2) begin failures++; $display("FAIL mid_count_hold %0d got=%h exp=%h", k, dout, 32'd2); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq %0d got=%b exp=0", k, irq); end
        end
        bus_write(0, 32'h9);
        tick();
        rd(2);
        checks++; if (dout !== 32'd2) begin failures++; $display("FAIL mid_restart_load got=%h exp=%h", dout, 32'd2); end
        tick();
        rd(2);
        checks++; if (dout !== 32'd5) begin failures++; $display("FAIL mid_restart_cnt got=%h exp=%h", dout, 32'd5); end
        bus_write(0, 32'h0);
    endtask

    task automatic test_masked();
        bus_write(1, 32'd0);
        bus_write(0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq T+%0d got=%b exp=0", k, irq); end
        end
        rd(0);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL masked_ctrl got=%h exp=%h", dout, 32'h0); end
        bus_write(0, 32'h9);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_flag_clear got=%b exp=0", irq); end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_rearm W+%0d got=%b exp=0", k, irq); end
        end
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL masked_rearm_fire got=%b exp=1", irq); end
        bus_write(0, 32'h0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_final_clear got=%b exp=0", irq); end
    endtask

    task automatic test_count_readonly();
        bus_write(1, 32'd5);
        bus_write(0, 32'h9);
        repeat (3) tick();
        rd(2);
        checks++; if (dout !== 32'd4) begin failures++; $display("FAIL ro_count_pre got=%h exp=%h", dout, 32'd4); end
        bus_write(2, 32'hFFFF);
        rd(2);
        checks++; if (dout !== 32'd3) begin failures++; $display("FAIL ro_count_write got=%h exp=%h", dout, 32'd3); end
        bus_write(3, 32'hDEAD_BEEF);
        rd(2);
        checks++; if (dout !== 32'd2) begin failures++; $display("FAIL ro_count_reg3 got=%h exp=%h", dout, 32'd2); end
        rd(3);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL ro_reg3 got=%h exp=%h", dout, 32'h0); end
        // Reset mid-count with a simultaneous CTRL write.
        reset = 1'b1;
        we    = 1'b1;
        addr  = '0;
        din   = 32'hF;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        din   = '0;
        rd(0);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rst_mid_ctrl got=%h exp=%h", dout, 32'h0); end
        rd(1);
        checks++; if (dout !== RP) begin failures++; $display("FAIL rst_mid_preset got=%h exp=%h", dout, RP); end
        rd(2);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rst_mid_count got=%h exp=%h", dout, 32'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
        repeat (3) tick();
        rd(2);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rst_mid_idle_count got=%h exp=%h", dout, 32'h0); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        we       = 1'b0;
        addr     = '0;
        din      = '0;
        test_reset();
        test_oneshot();
`ifdef TIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_mode_hardwired();
`endif
        test_midcount_stop();
        test_masked();
        test_count_readonly();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
